// File: rtl/l1_l2_arbiter.sv
// Arbitrates the shared L2 request port between the L1 I-cache and D-cache.
// The grant is registered, fairness is round-robin, and the ready pulse goes to the owner only.
module l1_l2_arbiter #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   read_I_L2,
    input  logic [ADDR_WIDTH-1:0]  addr_I_L2,
    output logic                   ready_L2_I,
    input  logic                   read_D_L2,
    input  logic                   write_D_L2,
    input  logic [ADDR_WIDTH-1:0]  addr_D_L2,
    input  logic [BLOCK_WIDTH-1:0] wdata_D_L2,
    output logic                   ready_L2_D,
    output logic                   read_L1_L2,
    output logic                   write_L1_L2,
    output logic [ADDR_WIDTH-1:0]  addr_L1_L2,
    output logic [BLOCK_WIDTH-1:0] wdata_L1_L2,
    input  logic                   ready_L2_L1,
    output logic [1:0]             grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   last_d, last_d_nxt;   // 1: D was served most recently
    logic   req_d;

    assign req_d = read_D_L2 | write_D_L2;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        case (state)
            IDLE: begin
                if (read_I_L2 && req_d)
                    state_nxt = last_d ? GNT_I : GNT_D;
                else if (read_I_L2)
                    state_nxt = GNT_I;
                else if (req_d)
                    state_nxt = GNT_D;
            end
            GNT_I: begin
                // On completion the owner's still-high request is ignored so it cannot win twice in a row
                if (ready_L2_L1) begin
                    last_d_nxt = 1'b0;
                    state_nxt  = req_d ? GNT_D : IDLE;
                end else if (!read_I_L2) begin
                    state_nxt = IDLE;
                end
            end
            GNT_D: begin
                if (ready_L2_L1) begin
                    last_d_nxt = 1'b1;
                    state_nxt  = read_I_L2 ? GNT_I : IDLE;
                end else if (!req_d) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        read_L1_L2  = 1'b0;
        write_L1_L2 = 1'b0;
        addr_L1_L2  = '0;
        wdata_L1_L2 = '0;
        ready_L2_I  = 1'b0;
        ready_L2_D  = 1'b0;
        case (state)
            GNT_I: begin
                read_L1_L2 = read_I_L2;
                addr_L1_L2 = addr_I_L2;
                ready_L2_I = ready_L2_L1;
            end
            GNT_D: begin
                write_L1_L2 = write_D_L2;
                read_L1_L2  = read_D_L2 & ~write_D_L2;
                addr_L1_L2  = addr_D_L2;
                wdata_L1_L2 = wdata_D_L2;
                ready_L2_D  = ready_L2_L1;
            end
            default: ;
        endcase
    end

    assign grant = state;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Bench for l1_l2_arbiter: directed scenarios plus random traffic, with every cycle
// compared against an ownership-based reference model.
module tb_l1_l2_arbiter;

    localparam int AW = 64;
    localparam int BW = 512;

    logic          clk = 1'b0;
    logic          nrst;
    logic          read_I_L2;
    logic [AW-1:0] addr_I_L2;
    logic          ready_L2_I;
    logic          read_D_L2;
    logic          write_D_L2;
    logic [AW-1:0] addr_D_L2;
    logic [BW-1:0] wdata_D_L2;
    logic          ready_L2_D;
    logic          read_L1_L2;
    logic          write_L1_L2;
    logic [AW-1:0] addr_L1_L2;
    logic [BW-1:0] wdata_L1_L2;
    logic          ready_L2_L1;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner 0 = nobody, 1 = I-cache, 2 = D-cache; last_srv is 1 or 2
    int m_owner;
    int m_last;

    l1_l2_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .read_I_L2   (read_I_L2),
        .addr_I_L2   (addr_I_L2),
        .ready_L2_I  (ready_L2_I),
        .read_D_L2   (read_D_L2),
        .write_D_L2  (write_D_L2),
        .addr_D_L2   (addr_D_L2),
        .wdata_D_L2  (wdata_D_L2),
        .ready_L2_D  (ready_L2_D),
        .read_L1_L2  (read_L1_L2),
        .write_L1_L2 (write_L1_L2),
        .addr_L1_L2  (addr_L1_L2),
        .wdata_L1_L2 (wdata_L1_L2),
        .ready_L2_L1 (ready_L2_L1),
        .grant       (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model after inputs have settled
    task automatic settle();
        logic          e_rd, e_wr, e_ri, e_rdy_d;
        logic [AW-1:0] e_addr;
        logic [BW-1:0] e_wdata;
        #1;
        e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_ri = 0; e_rdy_d = 0;
        if (nrst && m_owner == 1) begin
            e_rd = read_I_L2;
            e_addr = addr_I_L2;
            e_ri = ready_L2_L1;
        end else if (nrst && m_owner == 2) begin
            e_wr = write_D_L2;
            e_rd = read_D_L2 && !write_D_L2;
            e_addr = addr_D_L2;
            e_wdata = wdata_D_L2;
            e_rdy_d = ready_L2_L1;
        end
        check("grant", grant, nrst ? m_owner : 0);
        check("read_L1_L2", read_L1_L2, e_rd);
        check("write_L1_L2", write_L1_L2, e_wr);
        check("addr_L1_L2", addr_L1_L2, e_addr);
        check("wdata_L1_L2", wdata_L1_L2, e_wdata);
        check("ready_L2_I", ready_L2_I, e_ri);
        check("ready_L2_D", ready_L2_D, e_rdy_d);
    endtask

    // Apply this cycle's arbitration rules to the model, then move to the next drive point
    task automatic advance();
        bit req_i, req_d, mine, other_req;
        req_i = read_I_L2;
        req_d = read_D_L2 || write_D_L2;
        if (!nrst) begin
            m_owner = 0;
            m_last  = 2;
        end else if (m_owner == 0) begin
            if (req_i && req_d) m_owner = (m_last == 2) ? 1 : 2;
            else if (req_i)     m_owner = 1;
            else if (req_d)     m_owner = 2;
        end else begin
            mine      = (m_owner == 1) ? req_i : req_d;
            other_req = (m_owner == 1) ? req_d : req_i;
            if (ready_L2_L1) begin
                m_last  = m_owner;
                m_owner = other_req ? 3 - m_owner : 0;
            end else if (!mine) begin
                m_owner = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic quiet();
        read_I_L2 = 0; read_D_L2 = 0; write_D_L2 = 0; ready_L2_L1 = 0;
    endtask

    logic [1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        m_owner = 0; m_last = 2;
        nrst = 0;
        read_I_L2 = 1; read_D_L2 = 1; write_D_L2 = 1; ready_L2_L1 = 0;
        addr_I_L2 = 64'h1111_2222_3333_4440;
        addr_D_L2 = 64'h5555_6666_7777_8880;
        wdata_D_L2 = {8{64'hA5A5_0000_FFFF_1234}};

        // Reset held with everything requesting
        for (int unsigned i = 0; i < 5; i++) tick();
        check("reset_addr", addr_L1_L2, 0);
        write_D_L2 = 0;
        nrst = 1;
        tick();

        // Contention: last_served resets to D, so I wins first, then strict alternation
        for (int unsigned t = 0; t < 4; t++) begin
            ready_L2_L1 = 0;
            settle();
            check("contention_grant", grant, exp_seq[t]);
            advance();
            ready_L2_L1 = 1;
            settle();
            check("contention_grant_rdy", grant, exp_seq[t]);
            advance();
        end
        quiet();
        tick(); tick();

        // I only
        read_I_L2 = 1; addr_I_L2 = 64'h0000_0000_1234_5640;
        tick();
        settle();
        check("i_only_read", read_L1_L2, 1);
        check("i_only_addr", addr_L1_L2, 64'h0000_0000_1234_5640);
        advance();
        tick(); tick();
        ready_L2_L1 = 1;
        settle();
        check("i_only_ready_i", ready_L2_I, 1);
        check("i_only_ready_d", ready_L2_D, 0);
        advance();
        quiet();
        settle();
        check("i_only_idle", grant, 2'b00);
        advance();

        // D write-back has priority over the refill that is raised alongside it
        read_D_L2 = 1; write_D_L2 = 1; wdata_D_L2 = {8{64'hDEAD_BEEF_0000_0001}};
        tick();
        settle();
        check("wb_write", write_L1_L2, 1);
        check("wb_read", read_L1_L2, 0);
        check("wb_wdata", wdata_L1_L2, {8{64'hDEAD_BEEF_0000_0001}});
        advance();
        ready_L2_L1 = 1;
        tick();
        ready_L2_L1 = 0; write_D_L2 = 0;
        settle();
        check("wb_then_idle", grant, 2'b00);
        advance();
        settle();
        check("refill_grant", grant, 2'b10);
        check("refill_read", read_L1_L2, 1);
        advance();
        ready_L2_L1 = 1;
        tick();
        quiet();
        tick();

        // Serve I so last_served = I, then abort a D grant; the next contention must still favour D
        read_I_L2 = 1;
        tick();
        ready_L2_L1 = 1;
        tick();
        quiet();
        read_D_L2 = 1;
        tick();
        settle();
        check("abort_granted", grant, 2'b10);
        advance();
        read_D_L2 = 0;
        tick();
        settle();
        check("abort_idle", grant, 2'b00);
        advance();
        read_I_L2 = 1; read_D_L2 = 1;
        tick();
        settle();
        check("abort_keeps_last", grant, 2'b10);
        advance();
        quiet();
        tick();

        // Stray ready in IDLE
        tick();
        ready_L2_L1 = 1;
        settle();
        check("stray_ready_i", ready_L2_I, 0);
        check("stray_ready_d", ready_L2_D, 0);
        advance();
        quiet();

        // Reset mid-transaction drops the L2 command without waiting for a clock edge
        write_D_L2 = 1;
        tick();
        settle();
        nrst = 0;
        #1;
        check("async_rst_grant", grant, 2'b00);
        check("async_rst_write", write_L1_L2, 0);
        advance();
        nrst = 1;
        quiet();
        tick();

        // Random traffic
        for (int unsigned c = 0; c < 2000; c++) begin
            read_I_L2   = ($urandom_range(0, 9) < 6);
            read_D_L2   = ($urandom_range(0, 9) < 5);
            write_D_L2  = ($urandom_range(0, 9) < 3);
            ready_L2_L1 = ($urandom_range(0, 9) < 3);
            addr_I_L2   = {$urandom, $urandom};
            addr_D_L2   = {$urandom, $urandom};
            for (int unsigned w = 0; w < BW / 32; w++)
                wdata_D_L2[w*32 +: 32] = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
